// File: rtl/dot_channel_seq_pkg.sv
// Shared state encoding and field widths for the dot_channel_seq sequencer.
// Supplies a default `DATA_LEN when the datapath header has not already set it.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

package dot_channel_seq_pkg;
   localparam int CS_W    = 4;
   localparam int PHASE_W = 3;
   localparam int LAT_W   = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_RUN,
      ST_CAPTURE,
      ST_DONE
   } seq_state_t;
endpackage

// File: rtl/dot_channel_seq_tile_counter.sv
// Nested cs/phase tile counter: cs wraps at CS_NUM-1 and carries into phase.
module dot_channel_seq_tile_counter
   import dot_channel_seq_pkg::*;
#(
   parameter int CS_NUM    = 9,
   parameter int PHASE_NUM = 8
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               adv,
   output logic [CS_W-1:0]    cs,
   output logic [PHASE_W-1:0] phase,
   output logic               last
);
   localparam logic [CS_W-1:0]    CS_LAST    = CS_W'(CS_NUM - 1);
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASE_NUM - 1);

   logic [CS_W-1:0]    cs_reg;
   logic [PHASE_W-1:0] phase_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_reg    <= '0;
         phase_reg <= '0;
      end else if (clr) begin
         cs_reg    <= '0;
         phase_reg <= '0;
      end else if (adv) begin
         if (cs_reg == CS_LAST) begin
            cs_reg    <= '0;
            phase_reg <= (phase_reg == PHASE_LAST) ? '0 : phase_reg + 1'b1;
         end else begin
            cs_reg <= cs_reg + 1'b1;
         end
      end
   end

   assign cs    = cs_reg;
   assign phase = phase_reg;
   assign last  = (cs_reg == CS_LAST) && (phase_reg == PHASE_LAST);
endmodule

// File: rtl/dot_channel_seq.sv
// Tile sequencer for one dot channel: fetch weights, run the channel, capture q, re-arm.
// Define DOT_SEQ_TIMEOUT_EN to add the RUN watchdog that aborts the pass and raises err.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module dot_channel_seq
   import dot_channel_seq_pkg::*;
#(
   parameter int CS_NUM    = 9,
   parameter int PHASE_NUM = 8,
   parameter int WS_LAT    = 1,
   parameter int TIMEOUT   = 64
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 ws_load,
   output logic                 dc_load,
   output logic [CS_W-1:0]      cs,
   output logic [PHASE_W-1:0]   phase,
   input  logic                 dc_valid,
   input  logic [`DATA_LEN-1:0] dc_q,
   output logic                 out_valid,
   output logic [`DATA_LEN-1:0] out_data,
   output logic [CS_W-1:0]      out_cs,
   output logic [PHASE_W-1:0]   out_phase,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(WS_LAT - 1);

   seq_state_t           state_reg;
   logic [LAT_W-1:0]     lat_cnt_reg;
   logic                 ws_load_reg;
   logic                 dc_load_reg;
   logic                 out_valid_reg;
   logic                 in_ready_reg;
   logic                 busy_reg;
   logic                 done_reg;
   logic [`DATA_LEN-1:0] out_data_reg;
   logic [CS_W-1:0]      out_cs_reg;
   logic [PHASE_W-1:0]   out_phase_reg;
   logic                 cnt_clr;
   logic                 cnt_adv;
   logic                 last_tile;
   logic                 run_abort;

   // done_reg high means we are in the first IDLE cycle; a start there is dropped.
   assign cnt_clr = (state_reg == ST_IDLE) && start && !done_reg;
   assign cnt_adv = (state_reg == ST_CAPTURE);

   dot_channel_seq_tile_counter #(
      .CS_NUM    (CS_NUM),
      .PHASE_NUM (PHASE_NUM)
   ) u_tile_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .adv   (cnt_adv),
      .cs    (cs),
      .phase (phase),
      .last  (last_tile)
   );

`ifdef DOT_SEQ_TIMEOUT_EN
   localparam int RUN_W = $clog2(TIMEOUT + 1);

   logic [RUN_W-1:0] run_cnt_reg;
   logic             err_reg;

   assign run_abort = (state_reg == ST_RUN) && !dc_valid &&
                      (run_cnt_reg == RUN_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt_reg <= '0;
         err_reg     <= 1'b0;
      end else begin
         run_cnt_reg <= (state_reg == ST_RUN) ? run_cnt_reg + 1'b1 : '0;
         if (run_abort)
            err_reg <= 1'b1;
      end
   end

   assign err = err_reg;
`else
   assign run_abort = 1'b0;
   assign err       = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         lat_cnt_reg   <= '0;
         ws_load_reg   <= 1'b0;
         dc_load_reg   <= 1'b0;
         out_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         out_data_reg  <= '0;
         out_cs_reg    <= '0;
         out_phase_reg <= '0;
      end else begin
         out_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b0;
         done_reg      <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start && !done_reg) begin
                  state_reg   <= ST_FETCH;
                  ws_load_reg <= 1'b1;
                  busy_reg    <= 1'b1;
                  lat_cnt_reg <= '0;
               end
            end
            ST_FETCH: begin
               if (lat_cnt_reg != LAT_LAST) begin
                  lat_cnt_reg <= lat_cnt_reg + 1'b1;
               end else if (in_valid) begin
                  state_reg   <= ST_RUN;
                  dc_load_reg <= 1'b1;
               end
            end
            ST_RUN: begin
               // dc_valid is trusted only here; the channel's valid flop has no reset.
               if (dc_valid) begin
                  state_reg   <= ST_CAPTURE;
                  ws_load_reg <= 1'b0;
                  dc_load_reg <= 1'b0;
               end else if (run_abort) begin
                  state_reg   <= ST_DONE;
                  ws_load_reg <= 1'b0;
                  dc_load_reg <= 1'b0;
               end
            end
            ST_CAPTURE: begin
               out_data_reg  <= dc_q;
               out_cs_reg    <= cs;
               out_phase_reg <= phase;
               out_valid_reg <= 1'b1;
               in_ready_reg  <= 1'b1;
               if (last_tile) begin
                  state_reg <= ST_DONE;
               end else begin
                  state_reg   <= ST_FETCH;
                  ws_load_reg <= 1'b1;
                  lat_cnt_reg <= '0;
               end
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b1;
            end
            default: begin
               state_reg   <= ST_IDLE;
               ws_load_reg <= 1'b0;
               dc_load_reg <= 1'b0;
               busy_reg    <= 1'b0;
            end
         endcase
      end
   end

   assign ws_load   = ws_load_reg;
   assign dc_load   = dc_load_reg;
   assign out_valid = out_valid_reg;
   assign in_ready  = in_ready_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign out_data  = out_data_reg;
   assign out_cs    = out_cs_reg;
   assign out_phase = out_phase_reg;
endmodule

// File: tb/tb_dot_channel_seq.sv
// Randomized bench for dot_channel_seq: behavioural channel model plus an ordered tile scoreboard.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module tb_dot_channel_seq;
   localparam int CS_NUM    = 3;
   localparam int PHASE_NUM = 2;
   localparam int WS_LAT    = 2;
`ifdef DOT_SEQ_TIMEOUT_EN
   localparam int TIMEOUT = 16;
   localparam bit TO_EN   = 1'b1;
`else
   localparam int TIMEOUT = 64;
   localparam bit TO_EN   = 1'b0;
`endif
   localparam int N  = CS_NUM * PHASE_NUM;
   localparam int DW = `DATA_LEN;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          start    = 1'b0;
   logic          in_valid = 1'b0;
   logic          dc_valid = 1'b0;
   logic [DW-1:0] dc_q     = '0;
   logic          in_ready, ws_load, dc_load, out_valid, busy, done, err;
   logic [3:0]    cs, out_cs;
   logic [2:0]    phase, out_phase;
   logic [DW-1:0] out_data;

   dot_channel_seq #(
      .CS_NUM    (CS_NUM),
      .PHASE_NUM (PHASE_NUM),
      .WS_LAT    (WS_LAT),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ws_load   (ws_load),
      .dc_load   (dc_load),
      .cs        (cs),
      .phase     (phase),
      .dc_valid  (dc_valid),
      .dc_q      (dc_q),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_cs    (out_cs),
      .out_phase (out_phase),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference state: what the sequencer must do, derived from observed handshakes.
   logic [DW-1:0] tile_q [N];
   int  beats, ndone, fetch_i, run_len, ch_lat, iv_hold;
   bit  prev_ws_only, prev_in_valid, prev_dc_load, prev_dc_valid;
   bit  cap_d1, cap_d2, exp_busy, exp_done, err_exp;
   bit  start_req, force_v, chan_off, mid_starts, start_on_done;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      prev_ws_only = 0; prev_in_valid = 0; prev_dc_load = 0; prev_dc_valid = 0;
      fetch_i = 0; run_len = 0; cap_d1 = 0; cap_d2 = 0;
      exp_busy = 0; exp_done = 0; err_exp = 0; beats = 0; start_req = 0;
      start = 0; in_valid = 0; dc_valid = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq(tag, {ws_load, dc_load, out_valid, in_ready, busy, done, err,
                     cs, phase, out_cs, out_phase}, '0);
      check_eq({tag, "_data"}, out_data, '0);
   endtask

   task automatic step();
      bit ws_only, abort_now, accepted, vld, exp_stay, next_done;
      int idx;
      @(negedge clk);
      abort_now = 0;
      check_eq("load_order", dc_load & ~ws_load, 0);
      if (prev_ws_only)
         check_eq("fetch_gate", dc_load, (fetch_i >= WS_LAT) && prev_in_valid);
      if (prev_dc_load) begin
         abort_now = TO_EN && !prev_dc_valid && (run_len >= TIMEOUT);
         exp_stay  = !prev_dc_valid && !abort_now;
         check_eq("run_hold", {ws_load, dc_load}, exp_stay ? 2'b11 : 2'b00);
         if (abort_now) check_eq("err_set", err, 1);
      end
      check_eq("out_valid", out_valid, cap_d2);
      check_eq("in_ready", in_ready, out_valid);
      check_eq("done", done, exp_done);
      check_eq("busy", busy, exp_busy);
      if (out_valid) begin
         check_eq("beat_tag", {out_phase, out_cs}, {3'(beats / CS_NUM), 4'(beats % CS_NUM)});
         check_eq("beat_data", out_data, (beats < N) ? tile_q[beats] : '0);
         beats++;
      end
      if (done) begin
         ndone++;
         check_eq("err_at_done", err, err_exp);
      end

      ws_only   = ws_load && !dc_load;
      fetch_i   = ws_only ? (prev_ws_only ? fetch_i + 1 : 1) : 0;
      run_len   = dc_load ? (prev_dc_load ? run_len + 1 : 1) : 0;
      next_done = (out_valid && beats == N) || abort_now;
      if (abort_now) err_exp = 1;
      if (start_on_done && exp_done) start_req = 1;
      accepted = start_req && !exp_busy && !exp_done;
      if (accepted) begin
         beats = 0;
         for (int i = 0; i < N; i++) tile_q[i] = DW'($urandom);
      end

      // Channel: valid after 7..9 cycles of dc_load, q held until the next load.
      if (dc_load) begin
         if (!prev_dc_load) ch_lat = $urandom_range(9, 7);
         vld = !chan_off && (run_len >= ch_lat);
         if (vld) begin
            idx  = int'(phase) * CS_NUM + int'(cs);
            dc_q = (idx < N) ? tile_q[idx] : '0;
         end else begin
            dc_q = DW'($urandom);
         end
         dc_valid = vld;
      end else begin
         dc_valid = force_v && ($urandom_range(1, 0) == 1);
      end
      if (iv_hold > 0) begin
         in_valid = 1'b0;
         iv_hold--;
      end else begin
         in_valid = ($urandom_range(3, 0) != 0);
      end
      start     = start_req;
      start_req = 0;

      exp_busy      = accepted ? 1'b1 : (next_done ? 1'b0 : exp_busy);
      exp_done      = next_done;
      cap_d2        = cap_d1;
      cap_d1        = dc_load && dc_valid;
      prev_ws_only  = ws_only;
      prev_in_valid = in_valid;
      prev_dc_load  = dc_load;
      prev_dc_valid = dc_valid;
   endtask

   task automatic async_reset_check();
      #2 rst_n = 1'b0;
      #1 check_all_zero("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic run_pass(input int reset_at_beats);
      bit fin = 0;
      ndone     = 0;
      start_req = 1;
      for (int k = 0; k < 3000 && !fin; k++) begin
         if (mid_starts && exp_busy && $urandom_range(15, 0) == 0) start_req = 1;
         step();
         if (reset_at_beats >= 0 && dc_load && beats == reset_at_beats) begin
            async_reset_check();
            return;
         end
         if (done) fin = 1;
      end
      check_eq("pass_end", fin, 1);
      repeat (6) step();
      check_eq("single_done", ndone, 1);
      check_eq("beat_count", beats, chan_off ? 0 : N);
   endtask

   initial begin
      force_v = 0; chan_off = 0; mid_starts = 0; start_on_done = 0; iv_hold = 0;
      model_reset();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      iv_hold = 10;
      run_pass(-1);

      force_v = 1;
      run_pass(-1);
      force_v = 0;

      mid_starts = 1; start_on_done = 1;
      run_pass(-1);
      mid_starts = 0; start_on_done = 0;

      run_pass(2);
      run_pass(-1);

`ifdef DOT_SEQ_TIMEOUT_EN
      chan_off = 1;
      run_pass(-1);
      check_eq("err_sticky", err, 1);
      chan_off = 0;
`endif

      for (int p = 0; p < 4; p++) begin
         force_v = ($urandom_range(1, 0) == 1);
         run_pass(-1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
